// File: rtl/reset_sequencer.sv
// Releases per-subsystem resets one stage at a time in ascending order, waiting a fixed gap and
// then for each stage's ready ack; flags timeout or ready-loss faults with the offending stage.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_soft_rst,
  input  logic [NUM_STAGES-1:0] i_stage_ready,
  output logic [NUM_STAGES-1:0] o_stage_rst,
  output logic                  o_all_ready,
  output logic                  o_timeout_err,
  output logic [2:0]            o_err_stage
);

  typedef enum logic [1:0] {StHold, StWaitRdy, StDone, StFault} state_e;

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_ready_q, all_ready_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [2:0]            err_stage_q, err_stage_d;

  logic                  cur_ready;
  logic [NUM_STAGES-1:0] done_mask;
  logic [NUM_STAGES-1:0] lost_done;
  logic [NUM_STAGES-1:0] not_ready;
  logic                  fault;
  logic [2:0]            fault_stage;

  function automatic logic [2:0] lowest_set(input logic [NUM_STAGES-1:0] v);
    lowest_set = '0;
    for (int n = NUM_STAGES - 1; n >= 0; n--) begin
      if (v[n]) lowest_set = 3'(n);
    end
  endfunction

  always_comb begin
    cur_ready = 1'b0;
    done_mask = '0;
    for (int n = 0; n < NUM_STAGES; n++) begin
      if (idx_q == 3'(n)) cur_ready = i_stage_ready[n];
      if (3'(n) < idx_q)  done_mask[n] = 1'b1;
    end
    lost_done = done_mask & ~i_stage_ready;
    not_ready = ~i_stage_ready;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    stage_rst_d   = stage_rst_q;
    all_ready_d   = all_ready_q;
    timeout_err_d = timeout_err_q;
    err_stage_d   = err_stage_q;
    fault         = 1'b0;
    fault_stage   = idx_q;

    if (i_soft_rst) begin
      // Restart the sequence but keep the fault record for software to inspect.
      state_d     = StHold;
      idx_d       = '0;
      cnt_d       = '0;
      stage_rst_d = '1;
      all_ready_d = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
            for (int n = 0; n < NUM_STAGES; n++) begin
              if (idx_q == 3'(n)) stage_rst_d[n] = 1'b0;
            end
            cnt_d   = '0;
            state_d = StWaitRdy;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StWaitRdy: begin
          if (|lost_done) begin
            fault       = 1'b1;
            fault_stage = lowest_set(lost_done);
          end else if (cur_ready) begin
            cnt_d = '0;
            if (idx_q == 3'(NUM_STAGES - 1)) begin
              state_d     = StDone;
              all_ready_d = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = StHold;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            fault       = 1'b1;
            fault_stage = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (|not_ready) begin
            fault       = 1'b1;
            fault_stage = lowest_set(not_ready);
          end
        end
        StFault: ;
        default: state_d = StFault;
      endcase

      if (fault) begin
        state_d       = StFault;
        cnt_d         = '0;
        stage_rst_d   = '1;
        all_ready_d   = 1'b0;
        timeout_err_d = 1'b1;
        err_stage_d   = fault_stage;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q       <= StHold;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_rst_q   <= '1;
      all_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_rst_q   <= stage_rst_d;
      all_ready_q   <= all_ready_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign o_stage_rst   = stage_rst_q;
  assign o_all_ready   = all_ready_q;
  assign o_timeout_err = timeout_err_q;
  assign o_err_stage   = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: directed phases queue per-edge expectations, a negedge
// monitor pops and compares them against the registered outputs.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       soft_rst = 1'b0;
  logic [2:0] ready;
  logic [2:0] rst_o;
  logic       all_ready;
  logic       terr;
  logic [2:0] es;

  logic [2:0] auto_rdy   = '0;
  logic [2:0] force_low  = '0;
  logic [2:0] force_high = '0;
  int unsigned age [3];

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  rst;
    logic        all;
    logic        err;
    logic [2:0]  es;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ready = (auto_rdy & ~force_low) | force_high;

  reset_sequencer #(
    .NUM_STAGES (3),
    .STAGE_DELAY(4),
    .TIMEOUT    (32),
    .CNT_W      (16)
  ) u_dut (
    .i_sys_clk    (clk),
    .i_sys_rst    (sys_rst),
    .i_soft_rst   (soft_rst),
    .i_stage_ready(ready),
    .o_stage_rst  (rst_o),
    .o_all_ready  (all_ready),
    .o_timeout_err(terr),
    .o_err_stage  (es)
  );

  // Each stage model raises ready two edges after its reset is seen low.
  initial begin
    for (int n = 0; n < 3; n++) age[n] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int n = 0; n < 3; n++) begin
        if (rst_o[n] !== 1'b0) age[n] = 0;
        else if (age[n] < 1000) age[n] = age[n] + 1;
        auto_rdy[n] = (age[n] >= 2);
      end
    end
  end

  task automatic push(input int unsigned c, input logic [2:0] r, input logic a, input logic e,
                      input logic [2:0] s, input string nm);
    exp_t x;
    int   i;
    x.cyc = c; x.rst = r; x.all = a; x.err = e; x.es = s; x.name = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, x);
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_sys_rst(input logic with_soft, output int unsigned base);
    int unsigned c;
    c = cyc;
    sys_rst  = 1'b1;
    soft_rst = with_soft;
    goto(c + 1);
    push(c + 1, 3'b111, 1'b0, 1'b0, 3'd0, with_soft ? "sys_and_soft" : "sys_rst");
    soft_rst = 1'b0;
    goto(c + 2);
    push(c + 2, 3'b111, 1'b0, 1'b0, 3'd0, "sys_rst_hold");
    sys_rst = 1'b0;
    base = c + 2;
  endtask

  task automatic push_normal(input int unsigned b, input logic e, input logic [2:0] s,
                             input string nm);
    logic [2:0] r;
    for (int k = 1; k <= 18; k++) begin
      r = (k < 4) ? 3'b111 : (k < 10) ? 3'b110 : (k < 16) ? 3'b100 : 3'b000;
      push(b + k, r, (k >= 18), e, s, nm);
    end
  endtask

  // Monitor: compare every queued expectation on the falling edge after its clock edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        cur = sb.pop_front();
        checks++;
        if (cur.cyc < cyc) begin
          errors++;
          $display("FAIL %s missed at cyc=%0d (now %0d)", cur.name, cur.cyc, cyc);
        end else if ({rst_o, all_ready, terr, es} !== {cur.rst, cur.all, cur.err, cur.es}) begin
          errors++;
          $display("FAIL %s cyc=%0d got rst=%b all=%b err=%b es=%0d want rst=%b all=%b err=%b es=%0d",
                   cur.name, cyc, rst_o, all_ready, terr, es, cur.rst, cur.all, cur.err, cur.es);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    int unsigned s;
    logic [2:0]  r;
    @(posedge clk);
    #1;

    // Normal sequence
    do_sys_rst(1'b0, b);
    push_normal(b, 1'b0, 3'd0, "normal");
    goto(b + 18);

    // Timeout on stage 1
    force_low = 3'b010;
    do_sys_rst(1'b0, b);
    for (int k = 1; k <= 41; k++) begin
      r = (k < 4) ? 3'b111 : (k < 10) ? 3'b110 : 3'b100;
      push(b + k, r, 1'b0, 1'b0, 3'd0, "timeout_wait");
    end
    push(b + 42, 3'b111, 1'b0, 1'b1, 3'd1, "timeout_fault");
    push(b + 44, 3'b111, 1'b0, 1'b1, 3'd1, "fault_hold");
    goto(b + 44);

    // Soft reset recovery from FAULT
    force_low = '0;
    soft_rst  = 1'b1;
    s = b + 45;
    push(s, 3'b111, 1'b0, 1'b1, 3'd1, "soft_enter");
    push_normal(s, 1'b1, 3'd1, "soft_replay");
    goto(s);
    soft_rst = 1'b0;
    goto(s + 18);

    // Ready loss in DONE
    push(s + 19, 3'b000, 1'b1, 1'b1, 3'd1, "done_hold");
    push(s + 20, 3'b111, 1'b0, 1'b1, 3'd0, "ready_loss");
    goto(s + 19);
    force_low = 3'b001;
    goto(s + 20);
    force_low = '0;
    goto(s + 21);

    // Sys and soft together clear the sticky flag; then ready on the timeout edge
    force_low = 3'b010;
    do_sys_rst(1'b1, b);
    push(b + 41, 3'b100, 1'b0, 1'b0, 3'd0, "pre_timeout");
    push(b + 42, 3'b100, 1'b0, 1'b0, 3'd0, "ready_on_timeout");
    push(b + 45, 3'b100, 1'b0, 1'b0, 3'd0, "gap_after_late");
    push(b + 46, 3'b000, 1'b0, 1'b0, 3'd0, "last_release");
    push(b + 47, 3'b000, 1'b0, 1'b0, 3'd0, "not_yet_done");
    push(b + 48, 3'b000, 1'b1, 1'b0, 3'd0, "late_done");
    goto(b + 41);
    force_low = '0;
    goto(b + 48);

    // Soft reset while waiting on stage 2
    force_low = 3'b100;
    do_sys_rst(1'b0, b);
    push(b + 16, 3'b000, 1'b0, 1'b0, 3'd0, "stage2_released");
    push(b + 19, 3'b000, 1'b0, 1'b0, 3'd0, "stage2_wait");
    push(b + 20, 3'b111, 1'b0, 1'b0, 3'd0, "soft_mid");
    push(b + 23, 3'b111, 1'b0, 1'b0, 3'd0, "soft_mid_hold");
    push(b + 24, 3'b110, 1'b0, 1'b0, 3'd0, "re_release");
    goto(b + 19);
    soft_rst = 1'b1;
    goto(b + 20);
    soft_rst = 1'b0;
    goto(b + 24);
    force_low = '0;

    // Early ready: all stages report ready from reset
    force_high = 3'b111;
    do_sys_rst(1'b0, b);
    for (int k = 1; k <= 15; k++) begin
      r = (k < 4) ? 3'b111 : (k < 9) ? 3'b110 : (k < 14) ? 3'b100 : 3'b000;
      push(b + k, r, (k >= 15), 1'b0, 3'd0, "early_ready");
    end
    goto(b + 15);
    force_high = '0;
    goto(b + 16);
    @(negedge clk);
    #1;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits in the o_sys_clk domain, downstream of the clock/reset generator.
- Consumes the system synchronous reset and releases per-subsystem resets one stage at a time: SPDIF receiver, converter datapath, output, and so on.
- Before releasing the next stage, it waits a fixed gap and then for the current stage's ready acknowledgement.
- Reports completion, and flags timeout or ready-loss faults with the offending stage index.

Parameters:
- NUM_STAGES, 4, number of sequenced reset domains (1..8)
- STAGE_DELAY, 16, hold/gap cycles before each stage release (>=1)
- TIMEOUT, 4096, cycles allowed for a released stage to assert ready (>=2)
- CNT_W, 16, width of the shared delay/timeout counter; must hold max(STAGE_DELAY, TIMEOUT)

Ports:
- i_sys_clk  in  1  system clock; the only clock
- i_sys_rst  in  1  synchronous, active-high reset; highest priority
- i_soft_rst  in  1  single-cycle request to restart the full sequence
- i_stage_ready  in  NUM_STAGES  per-stage ready ack; bit n is high when stage n is out of reset and operational
- o_stage_rst  out  NUM_STAGES  per-stage synchronous active-high resets; bit n goes to stage n
- o_all_ready  out  1  all stages released and ready
- o_timeout_err  out  1  sticky fault flag
- o_err_stage  out  3  index of the stage that caused the last fault

Behaviour:
- All outputs are registered.
- Reset (i_sys_rst high at an edge):
  - o_stage_rst = all ones; o_all_ready = 0; o_timeout_err = 0; o_err_stage = 0.
  - idx = 0; counter = 0; state = HOLD.
- States: HOLD, WAIT_RDY, DONE, FAULT.
- HOLD:
  - counter increments each edge.
  - At the edge where counter == STAGE_DELAY-1: o_stage_rst[idx] <= 0; counter <= 0; state <= WAIT_RDY.
  - Therefore o_stage_rst[0] falls exactly STAGE_DELAY edges after the first edge with i_sys_rst low.
- WAIT_RDY:
  - counter increments each edge.
  - If i_stage_ready[idx] = 1:
    - When idx == NUM_STAGES-1: state <= DONE and o_all_ready <= 1 on that same edge.
    - Otherwise: idx <= idx+1; counter <= 0; state <= HOLD. The next stage is released STAGE_DELAY edges later.
  - Else if counter == TIMEOUT-1: FAULT with o_err_stage <= idx. Ready arriving on the timeout edge wins, so no fault is raised.
  - A low i_stage_ready bit for any already-completed stage (index < idx) also faults. o_err_stage = lowest such index. This check has priority over the current-stage checks.
- DONE:
  - o_all_ready held high.
  - Any i_stage_ready bit going low → FAULT, o_err_stage = lowest low index, o_all_ready <= 0 on that edge.
- FAULT entry edge:
  - o_timeout_err <= 1; o_stage_rst <= all ones; o_all_ready <= 0.
- FAULT state:
  - Remains until i_soft_rst or i_sys_rst.
- o_timeout_err:
  - Sticky. It is cleared only by i_sys_rst, not by i_soft_rst.
  - o_err_stage is overwritten by each new fault.
- i_soft_rst (any state):
  - Same-edge effect as reset, except that o_timeout_err and o_err_stage keep their values.
  - A soft reset mid-sequence re-asserts already-released stages immediately.
- Priority: i_sys_rst > i_soft_rst > FAULT detection > normal progress.
- Stage release order is strictly ascending. Exactly one o_stage_rst bit changes per release edge. No bit deasserts outside HOLD exit.
- Ready is not sampled for stages not yet released; an early-high ready bit is ignored until that stage's WAIT_RDY.
- Counter never wraps: it saturates by construction because each state exits at its terminal count.

Test Plan:
Bench parameters: NUM_STAGES=3, STAGE_DELAY=4, TIMEOUT=32.
1. Normal sequence:
   - Stimulus: deassert i_sys_rst at edge 0; each stage's ready rises 2 cycles after its reset falls.
   - Required: o_stage_rst goes 111→110 at edge 4, →100 at edge 10, →000 at edge 16; o_all_ready = 1 at edge 18.
2. Timeout:
   - Stimulus: stage 1 ready held low.
   - Required: fault exactly 32 edges after o_stage_rst[1] falls; o_timeout_err = 1, o_err_stage = 1, o_stage_rst = 111, o_all_ready = 0.
   - Also: ready raised on the timeout edge itself → no fault, sequence continues.
3. Ready loss in DONE:
   - Stimulus: drop i_stage_ready[0] for 1 cycle after o_all_ready = 1.
   - Required: next edge o_all_ready = 0, o_stage_rst = 111, o_err_stage = 0.
4. Soft reset recovery:
   - Stimulus: from FAULT, pulse i_soft_rst.
   - Required: o_stage_rst = 111, o_timeout_err stays 1, the full sequence replays with the case-1 timing, and o_all_ready = 1 is reached.
5. Soft reset mid-sequence and priority:
   - Stimulus: i_soft_rst while in WAIT_RDY for stage 2.
   - Required: stages 0 and 1 re-asserted on the next edge, and o_stage_rst[0] falls again 4 edges later.
   - Also: i_sys_rst and i_soft_rst asserted together → o_timeout_err cleared.
6. Early ready:
   - Stimulus: all i_stage_ready tied high from reset.
   - Required: releases spaced at STAGE_DELAY+1 edges (edges 4, 9, 14); o_all_ready = 1 at edge 15.
